// File: rtl/lcd_window_compositor.sv
// lcd_window_compositor
// Composites NUM_WIN fixed-size picture windows over a background colour.
// Window placement and enables are shadowed at the frame-start coordinate
// (0,0). Each active window owns an address counter that runs LEAD
// pixels ahead of the display position, so the external picture memory
// data lines up with pixel_data. The returned pixels are muxed onto
// pixel_data by fixed priority, with index 0 winning.
module lcd_window_compositor #(
  parameter int          NUM_WIN    = 3,
  parameter int          PIC_WIDTH  = 250,
  parameter int          PIC_HEIGHT = 114,
  parameter int          ADDR_W     = 15,
  parameter int          RD_LAT     = 1,
  parameter logic [23:0] BACK_COLOR = 24'hE0FFFF
) (
  input  logic                      lcd_pclk,
  input  logic                      rst,
  input  logic [10:0]               pixel_xpos,
  input  logic [10:0]               pixel_ypos,
  input  logic [NUM_WIN*11-1:0]     cfg_xs,
  input  logic [NUM_WIN*11-1:0]     cfg_ys,
  input  logic [NUM_WIN-1:0]        cfg_en,
  output logic [NUM_WIN*ADDR_W-1:0] win_addr,
  input  logic [NUM_WIN*24-1:0]     win_data,
  output logic [23:0]               pixel_data,
  output logic [NUM_WIN-1:0]        win_hit,
  output logic [NUM_WIN-1:0]        cfg_err
);

  // The address leads the display position by the memory latency plus
  // the output register stage.
  localparam int          LEAD   = RD_LAT + 1;
  localparam logic [11:0] LEAD_W = 12'(LEAD);
  localparam logic [11:0] WID_W  = 12'(PIC_WIDTH);
  localparam logic [11:0] HGT_W  = 12'(PIC_HEIGHT);

  // Shadow configuration and per-window address counters
  logic [10:0]        xs_r   [NUM_WIN];
  logic [10:0]        ys_r   [NUM_WIN];
  logic [NUM_WIN-1:0] en_r;
  logic [ADDR_W-1:0]  addr_r [NUM_WIN];
  logic [23:0]        pixel_data_r;
  logic [NUM_WIN-1:0] win_hit_r;
  logic [NUM_WIN-1:0] cfg_err_r;

  // Combinational decode
  logic               frame_start_s;
  logic [11:0]        x_ext_s;
  logic [11:0]        y_ext_s;
  logic [11:0]        xs_ext_s   [NUM_WIN];
  logic [11:0]        ys_ext_s   [NUM_WIN];
  logic [NUM_WIN-1:0] active_s;
  logic [NUM_WIN-1:0] row_in_s;
  logic [NUM_WIN-1:0] row_past_s;
  logic [NUM_WIN-1:0] lead_s;
  logic [NUM_WIN-1:0] disp_s;
  logic [NUM_WIN-1:0] cfg_err_next_s;
  logic [ADDR_W-1:0]  addr_next_s [NUM_WIN];
  logic [23:0]        sel_data_s;
  logic [NUM_WIN-1:0] sel_hit_s;

  // Region decode per window; all comparisons in 12 bits so xs+width never wraps
  always_comb begin
    frame_start_s  = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
    x_ext_s        = {1'b0, pixel_xpos};
    y_ext_s        = {1'b0, pixel_ypos};
    active_s       = '0;
    row_in_s       = '0;
    row_past_s     = '0;
    lead_s         = '0;
    disp_s         = '0;
    cfg_err_next_s = '0;
    for (int k = 0; k < NUM_WIN; k++) begin
      xs_ext_s[k]       = {1'b0, xs_r[k]};
      ys_ext_s[k]       = {1'b0, ys_r[k]};
      active_s[k]       = en_r[k] && (xs_ext_s[k] >= LEAD_W);
      row_in_s[k]       = (y_ext_s >= ys_ext_s[k]) && (y_ext_s < ys_ext_s[k] + HGT_W);
      row_past_s[k]     = (y_ext_s >= ys_ext_s[k] + HGT_W);
      lead_s[k]         = active_s[k] && row_in_s[k] &&
                          (x_ext_s + LEAD_W >= xs_ext_s[k]) &&
                          (x_ext_s + LEAD_W < xs_ext_s[k] + WID_W);
      disp_s[k]         = active_s[k] && row_in_s[k] &&
                          (x_ext_s + 12'd1 >= xs_ext_s[k]) &&
                          (x_ext_s + 12'd1 < xs_ext_s[k] + WID_W);
      cfg_err_next_s[k] = cfg_en[k] && ({1'b0, cfg_xs[k*11 +: 11]} < LEAD_W);
    end
  end

  // Next address per window: clear on frame start, inactivity or below the window
  always_comb begin
    for (int k = 0; k < NUM_WIN; k++) begin
      addr_next_s[k] = addr_r[k];
      if (frame_start_s) begin
        addr_next_s[k] = '0;
      end else if (!active_s[k]) begin
        addr_next_s[k] = '0;
      end else if (row_past_s[k]) begin
        addr_next_s[k] = '0;
      end else if (lead_s[k]) begin
        addr_next_s[k] = addr_r[k] + ADDR_W'(1);
      end else begin
        addr_next_s[k] = addr_r[k];
      end
    end
  end

  // Priority mux: scan from highest index down so the lowest index wins
  always_comb begin
    sel_data_s = BACK_COLOR;
    sel_hit_s  = '0;
    for (int k = NUM_WIN - 1; k >= 0; k--) begin
      sel_data_s = disp_s[k] ? win_data[k*24 +: 24] : sel_data_s;
      sel_hit_s  = disp_s[k] ? (NUM_WIN'(1'b1) << k) : sel_hit_s;
    end
  end

  // Shadow configuration latch and error flags, updated only at frame start
  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      en_r      <= '0;
      cfg_err_r <= '0;
      for (int k = 0; k < NUM_WIN; k++) begin
        xs_r[k] <= 11'd0;
        ys_r[k] <= 11'd0;
      end
    end else if (frame_start_s) begin
      en_r      <= cfg_en;
      cfg_err_r <= cfg_err_next_s;
      for (int k = 0; k < NUM_WIN; k++) begin
        xs_r[k] <= cfg_xs[k*11 +: 11];
        ys_r[k] <= cfg_ys[k*11 +: 11];
      end
    end
  end

  // Address counters and registered pixel output
  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      pixel_data_r <= BACK_COLOR;
      win_hit_r    <= '0;
      for (int k = 0; k < NUM_WIN; k++) begin
        addr_r[k] <= '0;
      end
    end else begin
      pixel_data_r <= sel_data_s;
      win_hit_r    <= sel_hit_s;
      for (int k = 0; k < NUM_WIN; k++) begin
        addr_r[k] <= addr_next_s[k];
      end
    end
  end

  // Pack the counters onto the flat address bus
  always_comb begin
    win_addr = '0;
    for (int k = 0; k < NUM_WIN; k++) begin
      win_addr[k*ADDR_W +: ADDR_W] = addr_r[k];
    end
  end

  assign pixel_data = pixel_data_r;
  assign win_hit    = win_hit_r;
  assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_lcd_window_compositor.sv
// Directed bench for lcd_window_compositor. Instance a has three windows
// with RD_LAT=1; instance b has one window with RD_LAT=3. Both share the
// coordinate stream, which the bench drives row by row. The picture
// memory models return {window id + 1, 5'b0, address} so every pixel
// identifies both its source window and its address.
module tb_lcd_window_compositor;

  localparam logic [23:0] BACK = 24'hE0FFFF;

  logic        clk;
  logic        rst;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;

  logic [32:0] cfg_xs_a;
  logic [32:0] cfg_ys_a;
  logic [2:0]  cfg_en_a;
  logic [44:0] win_addr_a;
  logic [71:0] win_data_a;
  logic [23:0] pixel_data_a;
  logic [2:0]  win_hit_a;
  logic [2:0]  cfg_err_a;

  logic [10:0] cfg_xs_b;
  logic [10:0] cfg_ys_b;
  logic [0:0]  cfg_en_b;
  logic [14:0] win_addr_b;
  logic [23:0] win_data_b;
  logic [23:0] pixel_data_b;
  logic [0:0]  win_hit_b;
  logic [0:0]  cfg_err_b;
  logic [23:0] pipe_b [2];

  int nvec;
  int nerr;

  lcd_window_compositor #(.NUM_WIN(3), .RD_LAT(1)) dut_a (
    .lcd_pclk  (clk),
    .rst       (rst),
    .pixel_xpos(pixel_xpos),
    .pixel_ypos(pixel_ypos),
    .cfg_xs    (cfg_xs_a),
    .cfg_ys    (cfg_ys_a),
    .cfg_en    (cfg_en_a),
    .win_addr  (win_addr_a),
    .win_data  (win_data_a),
    .pixel_data(pixel_data_a),
    .win_hit   (win_hit_a),
    .cfg_err   (cfg_err_a)
  );

  lcd_window_compositor #(.NUM_WIN(1), .RD_LAT(3)) dut_b (
    .lcd_pclk  (clk),
    .rst       (rst),
    .pixel_xpos(pixel_xpos),
    .pixel_ypos(pixel_ypos),
    .cfg_xs    (cfg_xs_b),
    .cfg_ys    (cfg_ys_b),
    .cfg_en    (cfg_en_b),
    .win_addr  (win_addr_b),
    .win_data  (win_data_b),
    .pixel_data(pixel_data_b),
    .win_hit   (win_hit_b),
    .cfg_err   (cfg_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle picture memories for instance a
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      win_data_a[k*24 +: 24] <= {4'(k + 1), 5'd0, win_addr_a[k*15 +: 15]};
    end
  end

  // Three-cycle picture memory for instance b
  always_ff @(posedge clk) begin
    pipe_b[0]  <= {4'd1, 5'd0, win_addr_b};
    pipe_b[1]  <= pipe_b[0];
    win_data_b <= pipe_b[1];
  end

  function automatic logic [23:0] px(input int id, input int addr);
    return {4'(id), 5'd0, 15'(addr)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive x0..x1 on row y, one coordinate per clock, then stop at the falling edge
  task automatic run(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) begin
      @(posedge clk);
      #1;
      pixel_xpos = 11'(x);
      pixel_ypos = 11'(y);
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nvec       = 0;
    nerr       = 0;
    rst        = 1'b1;
    pixel_xpos = 11'd799;
    pixel_ypos = 11'd479;
    cfg_xs_a   = {11'd0, 11'd0, 11'd10};
    cfg_ys_a   = {11'd0, 11'd0, 11'd10};
    cfg_en_a   = 3'b001;
    cfg_xs_b   = 11'd10;
    cfg_ys_b   = 11'd10;
    cfg_en_b   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_a",  32'(pixel_data_a), 32'(BACK));
    chk("rst_hit_a",  32'(win_hit_a), 32'd0);
    chk("rst_addr_a", 32'(win_addr_a[31:0]) | 32'(win_addr_a[44:32]), 32'd0);
    chk("rst_err_a",  32'(cfg_err_a), 32'd0);
    chk("rst_pix_b",  32'(pixel_data_b), 32'(BACK));
    rst = 1'b0;

    // Frame 1: single window at (10,10) in both instances
    run(0, 0, 0);
    run(10, 0, 6);
    chk("f1_addr_b_x6", 32'(win_addr_b), 32'd0);
    chk("f1_addr_a_x6", 32'(win_addr_a[14:0]), 32'd0);
    run(10, 7, 7);
    chk("f1_addr_b_x7", 32'(win_addr_b), 32'd1);
    chk("f1_addr_a_x7", 32'(win_addr_a[14:0]), 32'd0);
    run(10, 8, 8);
    chk("f1_addr_a_x8", 32'(win_addr_a[14:0]), 32'd0);
    run(10, 9, 9);
    chk("f1_addr_a_x9", 32'(win_addr_a[14:0]), 32'd1);
    chk("f1_pix_a_x9",  32'(pixel_data_a), 32'(BACK));
    chk("f1_hit_a_x9",  32'(win_hit_a), 32'd0);
    chk("f1_pix_b_x9",  32'(pixel_data_b), 32'(BACK));
    run(10, 10, 10);
    chk("f1_pix_a_10_10", 32'(pixel_data_a), 32'(px(1, 0)));
    chk("f1_hit_a_10_10", 32'(win_hit_a), 32'd1);
    chk("f1_pix_b_10_10", 32'(pixel_data_b), 32'(px(1, 0)));
    chk("f1_hit_b_10_10", 32'(win_hit_b), 32'd1);
    run(10, 11, 259);
    chk("f1_pix_a_259_10", 32'(pixel_data_a), 32'(px(1, 249)));
    chk("f1_pix_b_259_10", 32'(pixel_data_b), 32'(px(1, 249)));
    run(10, 260, 260);
    chk("f1_pix_a_260_10", 32'(pixel_data_a), 32'(BACK));
    chk("f1_hit_a_260_10", 32'(win_hit_a), 32'd0);
    chk("f1_pix_b_260_10", 32'(pixel_data_b), 32'(BACK));
    run(10, 261, 270);
    run(11, 0, 10);
    chk("f1_pix_a_10_11", 32'(pixel_data_a), 32'(px(1, 250)));
    chk("f1_pix_b_10_11", 32'(pixel_data_b), 32'(px(1, 250)));
    run(11, 11, 270);
    for (int y = 12; y <= 122; y++) begin
      run(y, 0, 270);
    end
    run(123, 0, 259);
    chk("f1_pix_a_259_123", 32'(pixel_data_a), 32'(px(1, 28499)));
    chk("f1_pix_b_259_123", 32'(pixel_data_b), 32'(px(1, 28499)));
    run(123, 260, 260);
    chk("f1_pix_a_260_123", 32'(pixel_data_a), 32'(BACK));
    run(123, 261, 270);
    chk("f1_addr_a_end", 32'(win_addr_a[14:0]), 32'd28500);
    chk("f1_addr_b_end", 32'(win_addr_b), 32'd28500);
    run(124, 0, 0);

    // Frame 2: move window 0 to x=300 in the middle of the frame
    run(0, 0, 0);
    chk("f2_addr_a_start", 32'(win_addr_a[14:0]), 32'd0);
    for (int y = 10; y <= 39; y++) begin
      run(y, 0, 270);
    end
    cfg_xs_a[10:0] = 11'd300;
    run(40, 0, 9);
    chk("f2_pix_a_9_40", 32'(pixel_data_a), 32'(BACK));
    run(40, 10, 10);
    chk("f2_pix_a_10_40", 32'(pixel_data_a), 32'(px(1, 7500)));
    chk("f2_hit_a_10_40", 32'(win_hit_a), 32'd1);
    run(40, 11, 20);

    // Frame 3: new placement, window 2 and instance b misconfigured
    cfg_xs_a[32:22] = 11'd1;
    cfg_ys_a[32:22] = 11'd0;
    cfg_en_a        = 3'b101;
    cfg_xs_b        = 11'd3;
    run(0, 0, 0);
    chk("f3_err_a_prelatch", 32'(cfg_err_a), 32'd0);
    run(10, 0, 5);
    chk("f3_err_a",   32'(cfg_err_a), 32'b100);
    chk("f3_err_b",   32'(cfg_err_b), 32'd1);
    chk("f3_addr_a2", 32'(win_addr_a[44:30]), 32'd0);
    chk("f3_pix_a_5", 32'(pixel_data_a), 32'(BACK));
    chk("f3_hit_a_5", 32'(win_hit_a), 32'd0);
    run(10, 6, 10);
    chk("f3_pix_a_10", 32'(pixel_data_a), 32'(BACK));
    chk("f3_pix_b_10", 32'(pixel_data_b), 32'(BACK));
    chk("f3_addr_b",   32'(win_addr_b), 32'd0);
    run(10, 11, 297);
    chk("f3_addr_a_297", 32'(win_addr_a[14:0]), 32'd0);
    run(10, 298, 299);
    chk("f3_addr_a_299", 32'(win_addr_a[14:0]), 32'd1);
    chk("f3_pix_a_299",  32'(pixel_data_a), 32'(BACK));
    run(10, 300, 300);
    chk("f3_pix_a_300", 32'(pixel_data_a), 32'(px(1, 0)));
    chk("f3_hit_a_300", 32'(win_hit_a), 32'd1);
    run(10, 301, 310);

    // Frame 4: overlapping windows, errors cleared at the latch
    cfg_xs_a = {11'd2, 11'd200, 11'd100};
    cfg_ys_a = {11'd0, 11'd60, 11'd50};
    cfg_en_a = 3'b111;
    cfg_xs_b = 11'd4;
    run(0, 0, 0);
    run(1, 0, 0);
    chk("f4_err_a", 32'(cfg_err_a), 32'd0);
    chk("f4_err_b", 32'(cfg_err_b), 32'd0);
    for (int y = 50; y <= 69; y++) begin
      run(y, 0, 450);
    end
    run(70, 0, 250);
    chk("f4_hit_a_250",   32'(win_hit_a), 32'b001);
    chk("f4_pix_a_250",   32'(pixel_data_a), 32'(px(1, 5150)));
    chk("f4_addr_a1_250", 32'(win_addr_a[29:15]), 32'd2552);
    run(70, 251, 360);
    chk("f4_hit_a_360",   32'(win_hit_a), 32'b010);
    chk("f4_pix_a_360",   32'(pixel_data_a), 32'(px(2, 2660)));
    chk("f4_addr_a1_360", 32'(win_addr_a[29:15]), 32'd2662);

    // Frame 5: reset in the middle of window 1
    run(0, 0, 0);
    run(60, 0, 400);
    chk("f5_pix_a_400", 32'(pixel_data_a), 32'(px(2, 200)));
    chk("f5_hit_a_400", 32'(win_hit_a), 32'b010);
    rst = 1'b1;
    #1;
    chk("f5_rst_pix_a",  32'(pixel_data_a), 32'(BACK));
    chk("f5_rst_hit_a",  32'(win_hit_a), 32'd0);
    chk("f5_rst_addr_a", 32'(win_addr_a[31:0]) | 32'(win_addr_a[44:32]), 32'd0);
    chk("f5_rst_pix_b",  32'(pixel_data_b), 32'(BACK));
    chk("f5_rst_addr_b", 32'(win_addr_b), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(60, 401, 410);
    chk("f5_post_pix_a", 32'(pixel_data_a), 32'(BACK));
    chk("f5_post_hit_a", 32'(win_hit_a), 32'd0);
    run(61, 0, 300);
    chk("f5_post_pix_a_61",  32'(pixel_data_a), 32'(BACK));
    chk("f5_post_addr_a_61", 32'(win_addr_a[31:0]) | 32'(win_addr_a[44:32]), 32'd0);
    run(0, 0, 0);
    run(60, 0, 200);
    chk("f6_hit_a_200", 32'(win_hit_a), 32'b001);
    chk("f6_id_a_200",  32'(pixel_data_a[23:20]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
